// File: rtl/senter_multi_hex.sv
// senter_multi_hex -- hex-entry front end for the board I/O path.
//
// Edits NCH registers of W bits (ND = W/4 nibbles) from debounced scanner
// key codes and debounced buttons. Each key is taken through a
// d_ready/readn handshake, so one key is accepted per d_ready assertion.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   btn[2:0]       levels: [0] cursor left, [1] next channel, [2] clear channel
//   en             entry enable (keys and buttons ignored when 0)
//   mode           0 = overwrite at cursor, 1 = shift-in from the LSB
//   d_ready, din   scanner key valid / key code (0..15 hex, 16 bksp, 17 commit)
//   readn          one-cycle low acknowledge of an accepted key
//   data           flattened registers, channel k at [k*W +: W]
//   sel            selected channel
//   commit         one-cycle pulse on bit sel when a commit key is accepted
//   blink          one-hot cursor indicator gated by the blink phase
module senter_multi_hex #(
    parameter int          NCH       = 4,
    parameter int          W         = 32,
    parameter logic [31:0] INIT0     = 32'h87654321,
    parameter logic [31:0] INIT1     = 32'h12345678,
    parameter int          BLINK_DIV = 24,
    localparam int         ND        = W / 4,
    localparam int         SW        = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int         CW        = (ND > 1) ? $clog2(ND) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           btn,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 d_ready,
    input  logic [4:0]           din,
    output logic                 readn,
    output logic [NCH*W-1:0]     data,
    output logic [SW-1:0]        sel,
    output logic [NCH-1:0]       commit,
    output logic [ND-1:0]        blink
);

    localparam logic [CW-1:0] CUR_MAX = CW'(ND - 1);
    localparam logic [SW-1:0] SEL_MAX = SW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, ACK, WAIT_REL} state_t;

    state_t                 state_q;
    logic                   readn_q;
    logic [NCH-1:0][W-1:0]  regs_q, regs_d;
    logic [CW-1:0]          cur_q, cur_d;
    logic [SW-1:0]          sel_q, sel_d;
    logic [NCH-1:0]         commit_q, commit_d;
    logic [2:0]             btn_q;
    logic [BLINK_DIV-1:0]   cnt_q;
    logic                   phase_q;

    logic                   key_acc;
    logic [2:0]             btn_rise;
    logic [CW-1:0]          cur_inc, cur_dec;
    logic [ND-1:0]          one_hot;

    assign key_acc  = (state_q == IDLE) && d_ready && en;
    assign btn_rise = btn & ~btn_q;
    assign cur_inc  = (cur_q == CUR_MAX) ? '0 : cur_q + 1'b1;
    assign cur_dec  = (cur_q == '0) ? CUR_MAX : cur_q - 1'b1;
    assign one_hot  = ND'(1);

    // Key action first, then button effects so that a same-cycle clear or
    // button cursor update wins over the key. Both use the pre-edge sel.
    always_comb begin
        regs_d   = regs_q;
        cur_d    = cur_q;
        sel_d    = sel_q;
        commit_d = '0;
        if (key_acc) begin
            if (!din[4]) begin
                if (!mode) begin
                    regs_d[sel_q][4*cur_q +: 4] = din[3:0];
                    cur_d = cur_dec;
                end else begin
                    regs_d[sel_q] = (regs_q[sel_q] << 4) | W'(din[3:0]);
                end
            end else if (din == 5'd16) begin
                if (!mode) begin
                    // backspace steps left first, then clears that nibble
                    regs_d[sel_q][4*cur_inc +: 4] = 4'h0;
                    cur_d = cur_inc;
                end else begin
                    regs_d[sel_q] = regs_q[sel_q] >> 4;
                end
            end else if (din == 5'd17) begin
                commit_d[sel_q] = 1'b1;
            end
        end
        if (en) begin
            if (btn_rise[0]) cur_d = cur_inc;
            if (btn_rise[1]) begin
                sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
                cur_d = CUR_MAX;
            end
            if (btn_rise[2]) begin
                regs_d[sel_q] = '0;
                cur_d         = CUR_MAX;
            end
        end
    end

    // Handshake FSM with registered readn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            readn_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (d_ready && en) begin
                    readn_q <= 1'b0;
                    state_q <= ACK;
                end
                ACK: begin
                    readn_q <= 1'b1;
                    state_q <= d_ready ? WAIT_REL : IDLE;
                end
                WAIT_REL: if (!d_ready) state_q <= IDLE;
                default: begin
                    readn_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) regs_q[k] <= '0;
            regs_q[0] <= W'(INIT0);
            regs_q[1] <= W'(INIT1);
            cur_q     <= CUR_MAX;
            sel_q     <= '0;
            commit_q  <= '0;
            btn_q     <= '0;
        end else begin
            regs_q    <= regs_d;
            cur_q     <= cur_d;
            sel_q     <= sel_d;
            commit_q  <= commit_d;
            btn_q     <= btn;
        end
    end

    // Free-running blink timebase; phase flips once per counter wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (&cnt_q) phase_q <= ~phase_q;
        end
    end

    assign readn  = readn_q;
    assign data   = regs_q;
    assign sel    = sel_q;
    assign commit = commit_q;
    assign blink  = phase_q ? (one_hot << cur_q) : '0;

endmodule

// File: tb/tb_senter_multi_hex.sv
module tb_senter_multi_hex;

    localparam int NCH = 4;
    localparam int W   = 32;
    localparam int ND  = 8;
    localparam int BD  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       btn = '0;
    logic             en = 1'b1;
    logic             mode = 1'b0;
    logic             d_ready = 1'b0;
    logic [4:0]       din = '0;
    logic             readn;
    logic [NCH*W-1:0] data;
    logic [1:0]       sel;
    logic [NCH-1:0]   commit;
    logic [ND-1:0]    blink;

    senter_multi_hex #(.NCH(NCH), .W(W), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .btn(btn), .en(en), .mode(mode),
        .d_ready(d_ready), .din(din), .readn(readn), .data(data),
        .sel(sel), .commit(commit), .blink(blink)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    int lowcnt = 0;

    // cycles since reset, used to predict the blink phase
    always @(posedge clk or posedge rst)
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;

    always @(negedge clk)
        if (readn === 1'b0) lowcnt <= lowcnt + 1;

    // reference model
    logic [W-1:0] m_data [NCH];
    int m_sel, m_cur;

    task automatic m_init();
        m_data[0] = 32'h87654321;
        m_data[1] = 32'h12345678;
        m_data[2] = 0;
        m_data[3] = 0;
        m_sel = 0;
        m_cur = ND - 1;
    endtask

    task automatic m_key(int code, bit md);
        logic [W-1:0] v;
        v = m_data[m_sel];
        if (code < 16) begin
            if (!md) begin
                v = (v & ~(32'hF << (4 * m_cur))) | (W'(code) << (4 * m_cur));
                m_cur = (m_cur + ND - 1) % ND;
            end else begin
                v = v * 16 + W'(code);
            end
        end else if (code == 16) begin
            if (!md) begin
                m_cur = (m_cur + 1) % ND;
                v = v & ~(32'hF << (4 * m_cur));
            end else begin
                v = v / 16;
            end
        end
        m_data[m_sel] = v;
    endtask

    task automatic m_btn(int i);
        if (i == 0) m_cur = (m_cur + 1) % ND;
        if (i == 1) begin m_sel = (m_sel + 1) % NCH; m_cur = ND - 1; end
        if (i == 2) begin m_data[m_sel] = 0; m_cur = ND - 1; end
    endtask

    function automatic logic [ND-1:0] exp_blink();
        logic [ND-1:0] one;
        one = 1;
        return (((ncyc >> BD) & 1) != 0) ? (one << m_cur) : '0;
    endfunction

    // stimulus helpers
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; btn = '0; en = 1'b1; mode = 1'b0; d_ready = 1'b0; din = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_init();
    endtask

    task automatic key(int code, bit md, int hold);
        @(negedge clk);
        mode = md; din = 5'(code); d_ready = 1'b1;
        repeat (hold) @(negedge clk);
        d_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        if (en) m_key(code, md);
    endtask

    task automatic press_btn(int i);
        @(negedge clk);
        btn[i] = 1'b1;
        @(negedge clk);
        btn = '0;
        if (en) m_btn(i);
    endtask

    task automatic wait_phase();
        int n;
        n = 0;
        @(negedge clk);
        while ((((ncyc >> BD) & 1) == 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // tests
    task automatic test_reset();
        do_reset();
        for (int k = 0; k < NCH; k++) begin
            checks++;
            if (data[k*W +: W] !== m_data[k]) begin
                errors++;
                $display("FAIL reset_data ch%0d got %h exp %h", k, data[k*W +: W], m_data[k]);
            end
        end
        checks++;
        if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
        checks++;
        if (readn !== 1'b1) begin errors++; $display("FAIL reset_readn got %b exp 1", readn); end
        checks++;
        if (blink !== '0) begin errors++; $display("FAIL reset_blink got %b exp 0", blink); end
        checks++;
        if (commit !== '0) begin errors++; $display("FAIL reset_commit got %b exp 0", commit); end
    endtask

    task automatic test_overwrite();
        int l0;
        do_reset();
        #1 l0 = lowcnt;
        key(10, 0, 5);
        key(11, 0, 5);
        checks++;
        if (lowcnt - l0 != 2) begin errors++; $display("FAIL ovr_acks got %0d exp 2", lowcnt - l0); end
        checks++;
        if (data[0 +: W] !== 32'hAB654321) begin
            errors++; $display("FAIL ovr_ch0 got %h exp AB654321", data[0 +: W]);
        end
        wait_phase();
        checks++;
        if (blink !== 8'b0010_0000) begin errors++; $display("FAIL ovr_cursor got %b exp 00100000", blink); end
    endtask

    task automatic test_shift();
        logic [W-1:0] expv [3];
        int codes [3];
        expv[0] = 32'h23456781; expv[1] = 32'h3456781F; expv[2] = 32'h03456781;
        codes[0] = 1; codes[1] = 15; codes[2] = 16;
        do_reset();
        press_btn(1);
        for (int i = 0; i < 3; i++) begin
            key(codes[i], 1, 3);
            checks++;
            if (data[W +: W] !== expv[i]) begin
                errors++; $display("FAIL shift_ch1 step%0d got %h exp %h", i, data[W +: W], expv[i]);
            end
        end
    endtask

    task automatic test_sel_commit();
        int cnt;
        logic [NCH-1:0] seen;
        do_reset();
        repeat (3) press_btn(1);
        @(negedge clk);
        checks++;
        if (sel !== 2'd3) begin errors++; $display("FAIL sel_three got %0d exp 3", sel); end
        press_btn(1);
        @(negedge clk);
        checks++;
        if (sel !== 2'd0) begin errors++; $display("FAIL sel_wrap got %0d exp 0", sel); end
        din = 5'd17; d_ready = 1'b1;
        cnt = 0; seen = '0;
        repeat (6) begin
            @(negedge clk);
            if (commit !== '0) begin cnt++; seen = commit; end
        end
        d_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cnt != 1 || seen !== 4'b0001) begin
            errors++; $display("FAIL commit_pulse cycles %0d value %b exp 1 cycle 0001", cnt, seen);
        end
        checks++;
        if (data[0 +: W] !== m_data[0]) begin
            errors++; $display("FAIL commit_nochange got %h exp %h", data[0 +: W], m_data[0]);
        end
    endtask

    task automatic test_clear_collision();
        int l0;
        do_reset();
        @(negedge clk);
        din = 5'd5; mode = 1'b0; d_ready = 1'b1; btn = 3'b100;
        @(negedge clk);
        btn = '0;
        repeat (3) @(negedge clk);
        d_ready = 1'b0;
        repeat (2) @(negedge clk);
        m_key(5, 0);
        m_btn(2);
        checks++;
        if (data[0 +: W] !== 32'h0) begin errors++; $display("FAIL clr_ch0 got %h exp 0", data[0 +: W]); end
        wait_phase();
        checks++;
        if (blink !== 8'b1000_0000) begin errors++; $display("FAIL clr_cursor got %b exp 10000000", blink); end
        en = 1'b0;
        #1 l0 = lowcnt;
        key(5, 0, 4);
        checks++;
        if (lowcnt != l0) begin errors++; $display("FAIL en_off_ack got %0d lows exp 0", lowcnt - l0); end
        for (int k = 0; k < NCH; k++) begin
            checks++;
            if (data[k*W +: W] !== m_data[k]) begin
                errors++; $display("FAIL en_off_data ch%0d got %h exp %h", k, data[k*W +: W], m_data[k]);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_ack();
        int l0;
        do_reset();
        @(negedge clk);
        din = 5'd3; mode = 1'b0; d_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (readn !== 1'b0) begin errors++; $display("FAIL rack_low got %b exp 0", readn); end
        rst = 1'b1;
        #1;
        checks++;
        if (readn !== 1'b1) begin errors++; $display("FAIL rack_readn got %b exp 1", readn); end
        checks++;
        if (data[0 +: W] !== 32'h87654321) begin
            errors++; $display("FAIL rack_init got %h exp 87654321", data[0 +: W]);
        end
        @(negedge clk);
        rst = 1'b0;
        m_init();
        #1 l0 = lowcnt;
        repeat (6) @(negedge clk);
        d_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        m_key(3, 0);
        checks++;
        if (lowcnt - l0 != 1) begin errors++; $display("FAIL rack_one_key got %0d exp 1", lowcnt - l0); end
        checks++;
        if (data[0 +: W] !== m_data[0]) begin
            errors++; $display("FAIL rack_data got %h exp %h", data[0 +: W], m_data[0]);
        end
    endtask

    task automatic test_random();
        int l0, elows, code;
        do_reset();
        for (int it = 0; it < 80; it++) begin
            en = ($urandom_range(0, 7) != 0);
            #1 l0 = lowcnt;
            elows = 0;
            if ($urandom_range(0, 9) < 7) begin
                code = ($urandom_range(0, 9) == 0) ? $urandom_range(18, 31) : $urandom_range(0, 17);
                key(code, 1'($urandom_range(0, 1)), $urandom_range(1, 4));
                if (en) elows = 1;
            end else begin
                press_btn($urandom_range(0, 2));
                @(negedge clk);
            end
            #1;
            checks++;
            if (lowcnt - l0 != elows) begin
                errors++; $display("FAIL rnd_ack it%0d got %0d exp %0d", it, lowcnt - l0, elows);
            end
            for (int k = 0; k < NCH; k++) begin
                checks++;
                if (data[k*W +: W] !== m_data[k]) begin
                    errors++; $display("FAIL rnd_data it%0d ch%0d got %h exp %h", it, k, data[k*W +: W], m_data[k]);
                end
            end
            checks++;
            if (sel !== 2'(m_sel)) begin errors++; $display("FAIL rnd_sel it%0d got %0d exp %0d", it, sel, m_sel); end
            checks++;
            if (blink !== exp_blink()) begin
                errors++; $display("FAIL rnd_blink it%0d got %b exp %b", it, blink, exp_blink());
            end
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_overwrite();
        test_shift();
        test_sel_commit();
        test_clear_collision();
        test_reset_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
